// File: rtl/reg_dest_scoreboard_pkg.sv
// ============================================================================
// Module      : reg_dest_scoreboard_pkg
// Description : Shared constants and types for the destination-register
//               pending-write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_dest_scoreboard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int DEF_CNT_W  = 2;
    localparam int TOTAL_W    = 8;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

`default_nettype wire

// File: rtl/reg_dest_scoreboard_if.sv
// ============================================================================
// Module      : reg_dest_scoreboard_if
// Description : Issue, write-back and status bundle of the register scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import reg_dest_scoreboard_pkg::*;

interface reg_dest_scoreboard_if;

    logic                     flush;
    logic                     issue_valid;
    reg_addr_t                issue_rd;
    reg_addr_t                issue_rs;
    reg_addr_t                issue_rt;
    logic                     issue_uses_rs;
    logic                     issue_uses_rt;
    logic                     issue_stall;
    logic                     wb_valid;
    reg_addr_t                wb_rd;
    logic [NUM_REGS-1:0]      busy_vec;
    logic [TOTAL_W-1:0]       pending_total;
    logic                     underflow_err;

    modport master (
        output flush, issue_valid, issue_rd, issue_rs, issue_rt,
               issue_uses_rs, issue_uses_rt, wb_valid, wb_rd,
        input  issue_stall, busy_vec, pending_total, underflow_err
    );

    modport slave (
        input  flush, issue_valid, issue_rd, issue_rs, issue_rt,
               issue_uses_rs, issue_uses_rt, wb_valid, wb_rd,
        output issue_stall, busy_vec, pending_total, underflow_err
    );

endinterface

`default_nettype wire

// File: rtl/reg_dest_scoreboard_pend_counter.sv
// ============================================================================
// Module      : reg_pend_counter
// Description : Per-register up/down pending-write counter with clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import reg_dest_scoreboard_pkg::*;

module reg_pend_counter #(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic is_zero,
    output logic is_one,
    output logic is_max
);

    logic [CNT_W-1:0] r_cnt;

    // Simultaneous inc and dec cancel; saturation guards keep the count in range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && !dec && !is_max) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (dec && !inc && !is_zero) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign is_zero = (r_cnt == '0);
    assign is_one  = (r_cnt == CNT_W'(1));
    assign is_max  = &r_cnt;

endmodule

`default_nettype wire

// File: rtl/reg_dest_scoreboard.sv
// ============================================================================
// Module      : reg_dest_scoreboard
// Description : Tracks outstanding register writes between decode and
//               write-back and raises a combinational issue stall on hazards.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import reg_dest_scoreboard_pkg::*;

module reg_dest_scoreboard #(
    parameter int CNT_W     = DEF_CNT_W,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    reg_dest_scoreboard_if.slave  sb
);

    logic [NUM_REGS-1:0] w_zero;
    logic [NUM_REGS-1:0] w_one;
    logic [NUM_REGS-1:0] w_max;
    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_dec;
    logic [NUM_REGS-1:0] w_hz;
    logic                w_wb_live;
    logic                w_full;
    logic                w_stall;
    logic                w_fire;
    logic                w_inc_any;
    logic                w_dec_any;
    logic                w_underflow;
    logic [TOTAL_W-1:0]  r_total;
    logic                r_underflow;

    assign w_wb_live = sb.wb_valid && (sb.wb_rd != REG_ZERO);

    genvar r;
    generate
        for (r = 0; r < NUM_REGS; r++) begin : g_reg
            if (r == 0) begin : g_zero
                assign w_zero[r] = 1'b1;
                assign w_one[r]  = 1'b0;
                assign w_max[r]  = 1'b0;
                assign w_inc[r]  = 1'b0;
                assign w_dec[r]  = 1'b0;
            end else begin : g_cnt
                assign w_inc[r] = w_fire && (sb.issue_rd == REG_ADDR_W'(r));
                assign w_dec[r] = w_wb_live && (sb.wb_rd == REG_ADDR_W'(r)) && !w_zero[r];

                reg_pend_counter #(
                    .CNT_W (CNT_W)
                ) u_cnt (
                    .clk     (clk),
                    .rst_n   (rst_n),
                    .inc     (w_inc[r]),
                    .dec     (w_dec[r]),
                    .clr     (sb.flush),
                    .is_zero (w_zero[r]),
                    .is_one  (w_one[r]),
                    .is_max  (w_max[r])
                );
            end
            // A retiring last write makes the register readable in the same cycle.
            assign w_hz[r] = !w_zero[r] &&
                             !(WB_BYPASS && w_wb_live && (sb.wb_rd == REG_ADDR_W'(r)) && w_one[r]);
        end
    endgenerate

    assign w_full  = (sb.issue_rd != REG_ZERO) && w_max[sb.issue_rd] &&
                     !(sb.wb_valid && (sb.wb_rd == sb.issue_rd));
    assign w_stall = sb.flush ||
                     (sb.issue_uses_rs && w_hz[sb.issue_rs]) ||
                     (sb.issue_uses_rt && w_hz[sb.issue_rt]) ||
                     w_full;
    assign w_fire  = sb.issue_valid && !w_stall;

    assign w_inc_any   = |w_inc;
    assign w_dec_any   = |w_dec;
    assign w_underflow = !sb.flush && w_wb_live && w_zero[sb.wb_rd] && !w_inc[sb.wb_rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_total     <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (sb.flush) begin
                r_total <= '0;
            end else if (w_inc_any && !w_dec_any && (r_total != '1)) begin
                r_total <= r_total + 1'b1;
            end else if (w_dec_any && !w_inc_any && (r_total != '0)) begin
                r_total <= r_total - 1'b1;
            end
            if (w_underflow) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign sb.issue_stall   = w_stall;
    assign sb.busy_vec      = ~w_zero;
    assign sb.pending_total = r_total;
    assign sb.underflow_err = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_reg_dest_scoreboard.sv
// ============================================================================
// Module      : tb_reg_dest_scoreboard
// Description : Directed and randomized checks of reg_dest_scoreboard against
//               an array-based model of pending writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_dest_scoreboard;

    localparam int CNT_W = 2;
    localparam bit BYP   = 1'b1;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reg_dest_scoreboard_if sb ();

    reg_dest_scoreboard #(
        .CNT_W     (CNT_W),
        .WB_BYPASS (BYP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb)
    );

    int m_cnt [32];
    bit m_uf;
    int total;
    int bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_hz(input int r, input bit wv, input int wrd);
        if (r == 0 || m_cnt[r] == 0) return 1'b0;
        if (BYP && wv && wrd == r && m_cnt[r] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] v = '0;
        for (int i = 1; i < 32; i++) if (m_cnt[i] != 0) v[i] = 1'b1;
        return v;
    endfunction

    function automatic int m_sum();
        int s = 0;
        for (int i = 1; i < 32; i++) s += m_cnt[i];
        return (s > 255) ? 255 : s;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    endtask

    // One clock: drive, check the combinational stall, then the registered state.
    task automatic step(input bit iv, input int rd, input int rs, input int rt,
                        input bit urs, input bit urt, input bit wv, input int wrd,
                        input bit fl);
        bit exp_st, inc, dec;
        sb.issue_valid   = iv;
        sb.issue_rd      = 5'(rd);
        sb.issue_rs      = 5'(rs);
        sb.issue_rt      = 5'(rt);
        sb.issue_uses_rs = urs;
        sb.issue_uses_rt = urt;
        sb.wb_valid      = wv;
        sb.wb_rd         = 5'(wrd);
        sb.flush         = fl;
        #2;
        exp_st = fl || (urs && m_hz(rs, wv, wrd)) || (urt && m_hz(rt, wv, wrd)) ||
                 (rd != 0 && m_cnt[rd] == MAXC && !(wv && wrd == rd));
        check("issue_stall", {31'd0, sb.issue_stall}, {31'd0, exp_st});
        @(posedge clk);
        if (fl) begin
            model_clear();
        end else begin
            inc = iv && !exp_st && rd != 0;
            dec = wv && wrd != 0 && m_cnt[wrd] > 0;
            if (wv && wrd != 0 && m_cnt[wrd] == 0 && !(inc && rd == wrd)) m_uf = 1'b1;
            if (inc) m_cnt[rd]++;
            if (dec) m_cnt[wrd]--;
        end
        #1;
        check("busy_vec", sb.busy_vec, m_busy());
        check("pending_total", {24'd0, sb.pending_total}, 32'(m_sum()));
        check("underflow_err", {31'd0, sb.underflow_err}, {31'd0, m_uf});
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic drive_idle();
        sb.issue_valid = 1'b0; sb.issue_rd = '0; sb.issue_rs = '0; sb.issue_rt = '0;
        sb.issue_uses_rs = 1'b0; sb.issue_uses_rt = 1'b0;
        sb.wb_valid = 1'b0; sb.wb_rd = '0; sb.flush = 1'b0;
    endtask

    // Reset pulse placed between clock edges: outputs must clear with no edge.
    task automatic async_reset();
        drive_idle();
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", sb.busy_vec, 32'h0);
        check("rst_total", {24'd0, sb.pending_total}, 32'h0);
        check("rst_uf", {31'd0, sb.underflow_err}, 32'h0);
        check("rst_stall", {31'd0, sb.issue_stall}, 32'h0);
        model_clear();
        m_uf = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rd, rs, rt, wrd;
        total = 0;
        bad   = 0;
        m_uf  = 1'b0;
        model_clear();
        rst_n = 1'b0;
        drive_idle();
        @(posedge clk);
        #1;
        check("reset_busy", sb.busy_vec, 32'h0);
        check("reset_total", {24'd0, sb.pending_total}, 32'h0);
        check("reset_uf", {31'd0, sb.underflow_err}, 32'h0);
        check("reset_stall", {31'd0, sb.issue_stall}, 32'h0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // RAW on a single pending write, then same-cycle retire bypass.
        step(1'b1, 5, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        check("busy_rd5", sb.busy_vec, 32'h0000_0020);
        check("total_rd5", {24'd0, sb.pending_total}, 32'd1);
        step(1'b1, 0, 5, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 0, 5, 0, 1'b1, 1'b0, 1'b1, 5, 1'b0);
        check("busy_bit5_clear", {31'd0, sb.busy_vec[5]}, 32'd0);

        // Saturation on r7 and the retire-same-cycle escape.
        for (int i = 0; i < 3; i++) step(1'b1, 7, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 7, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 7, 0, 0, 1'b0, 1'b0, 1'b1, 7, 1'b0);
        check("total_r7_sat", {24'd0, sb.pending_total}, 32'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 7, 1'b0);

        // Register zero is inert as destination, source and write-back target.
        for (int i = 0; i < 4; i++) step(1'b1, 0, 0, 0, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        check("r0_busy", sb.busy_vec, 32'h0);

        // Underflow is sticky across flush.
        step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 9, 1'b0);
        check("uf_set", {31'd0, sb.underflow_err}, 32'd1);
        step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        idle();

        // Flush with a concurrent issue drops everything.
        step(1'b1, 3, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 4, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 31, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 6, 0, 0, 1'b0, 1'b0, 1'b1, 3, 1'b1);
        check("flush_busy", sb.busy_vec, 32'h0);
        step(1'b1, 3, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 4, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        async_reset();

        for (int i = 0; i < 1500; i++) begin
            rd  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
            rs  = int'($urandom_range(0, 7));
            rt  = int'($urandom_range(0, 7));
            wrd = int'($urandom_range(0, 7));
            step(1'($urandom_range(0, 1)), rd, rs, rt, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), wrd,
                 ($urandom_range(0, 39) == 0));
            if (i % 300 == 299) async_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
